// File: rtl/picosoc_busarb_pkg.sv
// Shared state encoding and constants for the two-master PicoRV32 bus arbiter.
package picosoc_busarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA = 32'hBAD0_BAD0;

    // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never narrower than 1 bit.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/picosoc_busarb_wdog.sv
// Watchdog for the bus arbiter: counts stalled request cycles and flags an abort at the limit.
module picosoc_busarb_wdog
    import picosoc_busarb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    output logic abort
);

    localparam int            CW    = wdog_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Saturating at LIMIT keeps the counter from wrapping even if the grant lingers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign abort = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/picosoc_busarb.sv
// Two-master arbiter for a PicoRV32 native memory bus with round-robin/fixed priority and a watchdog abort.
module picosoc_busarb
    import picosoc_busarb_pkg::*;
#(
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        timeout_irq
);

    state_t state_q, state_d;
    logic   rr_q, rr_d;
    logic   irq_q;
    logic   granted;
    logic   wd_abort;
    logic   abort;
    logic   timed_out;
    logic   wd_en;

    assign granted   = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign abort     = wd_abort && granted;
    // A slave completion in the abort cycle wins over the timeout.
    assign timed_out = abort && !s_ready;
    assign wd_en     = granted && s_valid && !s_ready;

    picosoc_busarb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_q == ST_IDLE),
        .en     (wd_en),
        .abort  (wd_abort)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            irq_q   <= timed_out;
        end
    end

    assign timeout_irq = irq_q;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m0_err   = 1'b0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        m1_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    if (ROUND_ROBIN && rr_q) begin
                        state_d = ST_GRANT1;
                        rr_d    = 1'b0;
                    end else begin
                        state_d = ST_GRANT0;
                        rr_d    = 1'b1;
                    end
                end else if (m0_valid) begin
                    state_d = ST_GRANT0;
                    rr_d    = 1'b1;
                end else if (m1_valid) begin
                    state_d = ST_GRANT1;
                    rr_d    = 1'b0;
                end
            end

            ST_GRANT0: begin
                s_valid  = m0_valid && !abort;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready || abort;
                m0_err   = timed_out;
                m0_rdata = timed_out ? ERR_RDATA : s_rdata;
                // A master withdrawing its request also releases the bus, without a ready.
                if (!m0_valid || m0_ready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT1: begin
                s_valid  = m1_valid && !abort;
                s_instr  = m1_instr;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready || abort;
                m1_err   = timed_out;
                m1_rdata = timed_out ? ERR_RDATA : s_rdata;
                if (!m1_valid || m1_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_picosoc_busarb.sv
// Directed bench for picosoc_busarb: a round-robin instance and a fixed-priority instance share stimulus.
module tb_picosoc_busarb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, timeout_irq;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    logic        fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_s_valid, fp_s_instr, fp_timeout_irq;
    logic [31:0] fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    picosoc_busarb #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .timeout_irq(timeout_irq)
    );

    picosoc_busarb #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8)) u_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
        .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_wstrb(fp_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .timeout_irq(fp_timeout_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        cyc();
        resetn   = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        s_ready  = 1'b0;
        s_rdata  = '0;
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int exp_sv [6]  = '{0, 1, 0, 1, 0, 1};
        int exp_r0 [6]  = '{0, 1, 0, 0, 0, 1};
        int exp_r1 [6]  = '{0, 0, 0, 1, 0, 0};
        int exp_f0 [6]  = '{0, 1, 0, 1, 0, 1};

        resetn   = 1'b0;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata  = '0;

        // Reset state
        repeat (2) cyc();
        settle();
        chk("rst_rr_outs", 32'({m0_ready, m0_err, m1_ready, m1_err, s_valid, s_instr,
                                timeout_irq, s_wstrb}), 32'd0);
        chk("rst_rr_data", m0_rdata | m1_rdata | s_addr | s_wdata, 32'd0);
        chk("rst_fp_outs", 32'({fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err, fp_s_valid,
                                fp_s_instr, fp_timeout_irq, fp_s_wstrb}), 32'd0);
        chk("rst_fp_data", fp_m0_rdata | fp_m1_rdata | fp_s_addr | fp_s_wdata, 32'd0);
        cyc();
        resetn = 1'b1;

        // Single master read
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0; m0_instr = 1'b1;
        settle();
        chk("t1_idle_svalid", 32'(s_valid), 32'd0);
        cyc(); settle();
        chk("t1_g_svalid", 32'(s_valid), 32'd1);
        chk("t1_g_saddr", s_addr, 32'h0000_0010);
        chk("t1_g_sinstr", 32'(s_instr), 32'd1);
        chk("t1_g_m0ready", 32'(m0_ready), 32'd0);
        cyc(); settle();
        chk("t1_wait_svalid", 32'(s_valid), 32'd1);
        cyc();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        settle();
        chk("t1_m0ready", 32'(m0_ready), 32'd1);
        chk("t1_m0rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m0err", 32'(m0_err), 32'd0);
        chk("t1_m1_quiet", 32'({m1_ready, m1_err}), 32'd0);
        chk("t1_m1rdata", m1_rdata, 32'd0);
        cyc();
        m0_valid = 1'b0; m0_instr = 1'b0; s_ready = 1'b0; s_rdata = '0;
        settle();
        chk("t1_after_svalid", 32'(s_valid), 32'd0);
        chk("t1_after_m0ready", 32'(m0_ready), 32'd0);

        // Contention, both masters continuously requesting, slave answers at once
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) begin
                m0_valid = 1'b1; m0_addr = 32'h0000_0100;
                m1_valid = 1'b1; m1_addr = 32'h0000_0200;
                s_ready  = 1'b1; s_rdata = 32'hA5A5_0000;
            end
            settle();
            chk($sformatf("t2_svalid_%0d", i), 32'(s_valid), 32'(exp_sv[i]));
            chk($sformatf("t2_rr_m0ready_%0d", i), 32'(m0_ready), 32'(exp_r0[i]));
            chk($sformatf("t2_rr_m1ready_%0d", i), 32'(m1_ready), 32'(exp_r1[i]));
            chk($sformatf("t2_fp_m0ready_%0d", i), 32'(fp_m0_ready), 32'(exp_f0[i]));
            chk($sformatf("t2_fp_m1ready_%0d", i), 32'(fp_m1_ready), 32'd0);
            if (exp_r1[i] == 1) chk($sformatf("t2_rr_saddr_%0d", i), s_addr, 32'h0000_0200);
            if (exp_r0[i] == 1) chk($sformatf("t2_rr_saddr_%0d", i), s_addr, 32'h0000_0100);
        end
        cyc();
        m0_valid = 1'b0;
        settle();
        chk("t2_drop_svalid", 32'({s_valid, fp_s_valid}), 32'd0);
        cyc(); settle();
        chk("t2_rr_m1ready_last", 32'(m1_ready), 32'd1);
        chk("t2_fp_m1ready_last", 32'(fp_m1_ready), 32'd1);
        chk("t2_fp_saddr_last", fp_s_addr, 32'h0000_0200);
        cyc();
        m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        settle();

        // Timeout: m1 write, slave never answers
        cyc();
        m1_valid = 1'b1; m1_addr = 32'h0000_0300; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        settle();
        chk("t3_idle_svalid", 32'(s_valid), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc(); settle();
            chk($sformatf("t3_svalid_%0d", i), 32'(s_valid), 32'd1);
            chk($sformatf("t3_m1ready_%0d", i), 32'(m1_ready), 32'd0);
        end
        chk("t3_swstrb", 32'(s_wstrb), 32'hF);
        cyc(); settle();
        chk("t3_abort_svalid", 32'(s_valid), 32'd0);
        chk("t3_abort_m1ready", 32'(m1_ready), 32'd1);
        chk("t3_abort_m1err", 32'(m1_err), 32'd1);
        chk("t3_abort_rdata", m1_rdata, 32'hBAD0_BAD0);
        chk("t3_abort_irq_early", 32'(timeout_irq), 32'd0);
        chk("t3_fp_abort_m1err", 32'(fp_m1_err), 32'd1);
        cyc();
        m1_valid = 1'b0; m1_wstrb = 4'h0;
        settle();
        chk("t3_irq", 32'(timeout_irq), 32'd1);
        chk("t3_after_svalid", 32'(s_valid), 32'd0);
        chk("t3_after_m1ready", 32'(m1_ready), 32'd0);
        cyc(); settle();
        chk("t3_irq_off", 32'(timeout_irq), 32'd0);

        // Race: slave completes in the abort cycle
        cyc();
        m1_valid = 1'b1; m1_addr = 32'h0000_0304;
        settle();
        for (int i = 1; i <= 8; i++) begin
            cyc(); settle();
        end
        chk("t4_svalid_8", 32'(s_valid), 32'd1);
        cyc();
        s_ready = 1'b1; s_rdata = 32'h55AA_55AA;
        settle();
        chk("t4_m1ready", 32'(m1_ready), 32'd1);
        chk("t4_m1err", 32'(m1_err), 32'd0);
        chk("t4_m1rdata", m1_rdata, 32'h55AA_55AA);
        cyc();
        m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        settle();
        chk("t4_no_irq", 32'(timeout_irq), 32'd0);
        cyc(); settle();
        chk("t4_no_irq2", 32'(timeout_irq), 32'd0);

        // Reset in the middle of a GRANT1 transaction with the counter at 5
        cyc();
        m1_valid = 1'b1; m1_addr = 32'h0000_0308; m1_wstrb = 4'h3;
        settle();
        for (int i = 1; i <= 5; i++) begin
            cyc(); settle();
        end
        chk("t5_pre_svalid", 32'(s_valid), 32'd1);
        cyc();
        resetn = 1'b0;
        settle();
        chk("t5_rst_ctrl", 32'({s_valid, m1_ready, m1_err, m0_ready, timeout_irq}), 32'd0);
        chk("t5_rst_saddr", s_addr, 32'd0);
        chk("t5_rst_swstrb", 32'(s_wstrb), 32'd0);
        m1_valid = 1'b0; m1_wstrb = 4'h0;
        cyc();
        resetn = 1'b1;
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h0000_0400;
        m1_valid = 1'b1;
        settle();
        chk("t5_idle_svalid", 32'(s_valid), 32'd0);
        cyc(); settle();
        chk("t5_m0_first", s_addr, 32'h0000_0400);
        chk("t5_m1ready", 32'(m1_ready), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            cyc(); settle();
        end
        chk("t5_no_early_abort", 32'({s_valid, m0_ready}), 32'b10);
        cyc(); settle();
        chk("t5_fresh_abort", 32'({m0_ready, m0_err}), 32'b11);
        cyc();
        m0_valid = 1'b0; m1_valid = 1'b0;
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
